// File: rtl/adat_frame_deframer_if.sv
// Bit-stream and deframed-output bundle between the NRZI decoder side and the ADAT deframer.
// A bit is transferred on any cycle with bit_en_i=1 and there is no backpressure. Every output is a registered
// level or a one-cycle pulse that follows the accepted bit by exactly one clock.
interface adat_frame_deframer_if;
  logic        bit_en_i;
  logic        bit_data_i;
  logic        bit_valid_i;
  logic [23:0] sample_o;
  logic [2:0]  channel_o;
  logic        sample_valid_o;
  logic [3:0]  user_bits_o;
  logic        frame_start_o;
  logic        locked_o;
  logic        sync_error_o;
  logic [1:0]  dbg_state_o;

  modport master (
    output bit_en_i, bit_data_i, bit_valid_i,
    input  sample_o, channel_o, sample_valid_o, user_bits_o,
    input  frame_start_o, locked_o, sync_error_o, dbg_state_o
  );

  modport slave (
    input  bit_en_i, bit_data_i, bit_valid_i,
    output sample_o, channel_o, sample_valid_o, user_bits_o,
    output frame_start_o, locked_o, sync_error_o, dbg_state_o
  );
endinterface

// File: rtl/adat_frame_deframer.sv
// ADAT deframer: hunts for the 10-zero sync, strips the nibble separators, and emits the user bits
// and eight 24-bit samples for each 256-bit frame.
module adat_frame_deframer #(
  parameter int SYNC_ZEROS   = 10,
  parameter int NUM_CHANNELS = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  adat_frame_deframer_if.slave bus
);
  localparam logic [1:0] StHunt = 2'd0;
  localparam logic [1:0] StUser = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StSync = 2'd3;

  localparam logic [3:0] SyncZ    = 4'(SYNC_ZEROS);
  localparam logic [2:0] SepPos   = 3'd4;
  localparam logic [2:0] LastNib  = 3'd5;
  localparam logic [2:0] LastChan = 3'(NUM_CHANNELS - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  zero_cnt_q, zero_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [2:0]  chan_cnt_q, chan_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] sample_q, sample_d;
  logic [2:0]  channel_q, channel_d;
  logic        sample_valid_q, sample_valid_d;
  logic [3:0]  user_bits_q, user_bits_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        sync_error_q, sync_error_d;

  always_comb begin
    state_d        = state_q;
    zero_cnt_d     = zero_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    nib_cnt_d      = nib_cnt_q;
    chan_cnt_d     = chan_cnt_q;
    shift_d        = shift_q;
    sample_d       = sample_q;
    channel_d      = channel_q;
    user_bits_d    = user_bits_q;
    locked_d       = locked_q;
    sample_valid_d = 1'b0;
    frame_start_d  = 1'b0;
    sync_error_d   = 1'b0;

    if (bus.bit_en_i) begin
      // Loss of decoder sync overrides any framing check on the same bit.
      if (!bus.bit_valid_i) begin
        state_d    = StHunt;
        locked_d   = 1'b0;
        zero_cnt_d = '0;
      end else begin
        case (state_q)
          StHunt: begin
            if (!bus.bit_data_i) begin
              if (zero_cnt_q != 4'hF) zero_cnt_d = zero_cnt_q + 4'd1;
            end else begin
              zero_cnt_d = '0;
              if (zero_cnt_q >= SyncZ) begin
                frame_start_d = 1'b1;
                state_d       = StUser;
                bit_cnt_d     = '0;
                nib_cnt_d     = '0;
                chan_cnt_d    = '0;
              end
            end
          end
          StUser: begin
            if (bit_cnt_q != SepPos) begin
              shift_d   = {shift_q[22:0], bus.bit_data_i};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end else if (bus.bit_data_i) begin
              user_bits_d = shift_q[3:0];
              bit_cnt_d   = '0;
              state_d     = StData;
            end else begin
              sync_error_d = 1'b1;
              locked_d     = 1'b0;
              zero_cnt_d   = '0;
              state_d      = StHunt;
            end
          end
          StData: begin
            if (bit_cnt_q != SepPos) begin
              shift_d   = {shift_q[22:0], bus.bit_data_i};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end else if (!bus.bit_data_i) begin
              sync_error_d = 1'b1;
              locked_d     = 1'b0;
              zero_cnt_d   = '0;
              state_d      = StHunt;
            end else begin
              bit_cnt_d = '0;
              if (nib_cnt_q == LastNib) begin
                nib_cnt_d      = '0;
                sample_d       = shift_q;
                channel_d      = chan_cnt_q;
                sample_valid_d = 1'b1;
                chan_cnt_d     = chan_cnt_q + 3'd1;
                if (chan_cnt_q == LastChan) begin
                  zero_cnt_d = '0;
                  state_d    = StSync;
                end
              end else begin
                nib_cnt_d = nib_cnt_q + 3'd1;
              end
            end
          end
          default: begin // StSync
            if (!bus.bit_data_i) begin
              // One zero too many: preset the hunt count so the closing 1 still resyncs.
              if (zero_cnt_q == SyncZ) begin
                sync_error_d = 1'b1;
                locked_d     = 1'b0;
                zero_cnt_d   = SyncZ + 4'd1;
                state_d      = StHunt;
              end else begin
                zero_cnt_d = zero_cnt_q + 4'd1;
              end
            end else if (zero_cnt_q == SyncZ) begin
              frame_start_d = 1'b1;
              locked_d      = 1'b1;
              zero_cnt_d    = '0;
              bit_cnt_d     = '0;
              nib_cnt_d     = '0;
              chan_cnt_d    = '0;
              state_d       = StUser;
            end else begin
              sync_error_d = 1'b1;
              locked_d     = 1'b0;
              zero_cnt_d   = '0;
              state_d      = StHunt;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StHunt;
      zero_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      nib_cnt_q      <= '0;
      chan_cnt_q     <= '0;
      shift_q        <= '0;
      sample_q       <= '0;
      channel_q      <= '0;
      sample_valid_q <= 1'b0;
      user_bits_q    <= '0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
      sync_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      zero_cnt_q     <= zero_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      nib_cnt_q      <= nib_cnt_d;
      chan_cnt_q     <= chan_cnt_d;
      shift_q        <= shift_d;
      sample_q       <= sample_d;
      channel_q      <= channel_d;
      sample_valid_q <= sample_valid_d;
      user_bits_q    <= user_bits_d;
      frame_start_q  <= frame_start_d;
      locked_q       <= locked_d;
      sync_error_q   <= sync_error_d;
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.channel_o      = channel_q;
  assign bus.sample_valid_o = sample_valid_q;
  assign bus.user_bits_o    = user_bits_q;
  assign bus.frame_start_o  = frame_start_q;
  assign bus.locked_o       = locked_q;
  assign bus.sync_error_o   = sync_error_q;
  assign bus.dbg_state_o    = state_q;
endmodule

// File: tb/tb_adat_frame_deframer.sv
// Bench for adat_frame_deframer: builds ADAT frames from random channel values and checks decoded
// samples, pulses and lock status against expectations derived from the frame layout.
module tb_adat_frame_deframer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adat_frame_deframer_if bus();
  adat_frame_deframer #(.SYNC_ZEROS(10), .NUM_CHANNELS(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];
  int fs_cnt = 0;
  int se_cnt = 0;
  logic snap_fs, snap_se, snap_lock;
  logic sync_pre_lock, sync_pre_se;
  logic inj_se, inj_lock;
  int inj_idx;
  logic [23:0] ch_val[8];
  logic [3:0] user_val;
  logic [1:0] frm_q[$]; // {valid, data}

  // Monitor: every observed sample and every cycle a pulse is high.
  always @(negedge clk) begin
    if (bus.sample_valid_o) obs_q.push_back({bus.channel_o, bus.sample_o});
    if (bus.frame_start_o) fs_cnt++;
    if (bus.sync_error_o) se_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic d, input logic v);
    @(negedge clk);
    bus.bit_en_i = 1'b1; bus.bit_data_i = d; bus.bit_valid_i = v;
    @(negedge clk);
    snap_fs = bus.frame_start_o; snap_se = bus.sync_error_o; snap_lock = bus.locked_o;
    bus.bit_en_i = 1'b0; bus.bit_data_i = 1'($urandom); bus.bit_valid_i = 1'($urandom);
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  task automatic send_sync(input int zeros);
    for (int i = 0; i < zeros; i++) send_bit(1'b0, 1'b1);
    sync_pre_lock = snap_lock; sync_pre_se = snap_se;
    send_bit(1'b1, 1'b1);
  endtask

  // kind 1: separator forced to 0; kind 2: separator 0 with bit_valid low.
  function automatic void build_body(input int err_ch, input int err_nib, input int kind);
    frm_q.delete();
    inj_idx = -1;
    for (int b = 3; b >= 0; b--) frm_q.push_back({1'b1, user_val[b]});
    frm_q.push_back(2'b11);
    for (int c = 0; c < 8; c++)
      for (int n = 0; n < 6; n++) begin
        for (int b = 0; b < 4; b++) frm_q.push_back({1'b1, ch_val[c][23 - 4*n - b]});
        if (c == err_ch && n == err_nib) begin
          inj_idx = frm_q.size();
          frm_q.push_back(kind == 1 ? 2'b10 : 2'b00);
        end else frm_q.push_back(2'b11);
      end
  endfunction

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      send_bit(frm_q[i][0], frm_q[i][1]);
      if (i == inj_idx) begin inj_se = snap_se; inj_lock = snap_lock; end
    end
  endtask

  function automatic void new_vals();
    user_val = 4'($urandom_range(1, 15));
    for (int c = 0; c < 8; c++) ch_val[c] = 24'($urandom);
  endfunction

  function automatic void expect_chans(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back({3'(c), ch_val[c]});
  endfunction

  task automatic good_body();
    new_vals(); build_body(-1, 0, 0); send_range(0, frm_q.size()); expect_chans(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.bit_en_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete(); fs_cnt = 0; se_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.bit_en_i = 1'b0; bus.bit_data_i = 1'b0; bus.bit_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.sample_o !== 24'h0) begin n_fail++; $display("FAIL reset_sample: got %h want 0", bus.sample_o); end
    n_checks++; if (bus.channel_o !== 3'h0) begin n_fail++; $display("FAIL reset_channel: got %h want 0", bus.channel_o); end
    n_checks++; if (bus.sample_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_sv: got %b want 0", bus.sample_valid_o); end
    n_checks++; if (bus.user_bits_o !== 4'h0) begin n_fail++; $display("FAIL reset_user: got %h want 0", bus.user_bits_o); end
    n_checks++; if (bus.frame_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", bus.frame_start_o); end
    n_checks++; if (bus.locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", bus.locked_o); end
    n_checks++; if (bus.sync_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_se: got %b want 0", bus.sync_error_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_good_frames();
    do_reset();
    user_val = 4'hA;
    for (int c = 0; c < 8; c++) ch_val[c] = 24'hA00000 + 24'(c);
    send_sync(10);
    n_checks++; if (snap_fs !== 1'b1) begin n_fail++; $display("FAIL good_fs1: got %b want 1", snap_fs); end
    n_checks++; if (snap_lock !== 1'b0) begin n_fail++; $display("FAIL good_lock1: got %b want 0", snap_lock); end
    build_body(-1, 0, 0); send_range(0, frm_q.size()); expect_chans(8);
    send_sync(10);
    n_checks++; if (sync_pre_lock !== 1'b0) begin n_fail++; $display("FAIL good_lock_pre: got %b want 0", sync_pre_lock); end
    n_checks++; if (snap_lock !== 1'b1) begin n_fail++; $display("FAIL good_lock_rise: got %b want 1", snap_lock); end
    build_body(-1, 0, 0); send_range(0, frm_q.size()); expect_chans(8);
    send_sync(10);
    build_body(-1, 0, 0); send_range(0, frm_q.size()); expect_chans(8);
    n_checks++; if (fs_cnt !== 3) begin n_fail++; $display("FAIL good_fs_count: got %0d want 3", fs_cnt); end
    n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL good_se_count: got %0d want 0", se_cnt); end
    n_checks++; if (bus.user_bits_o !== 4'hA) begin n_fail++; $display("FAIL good_user: got %h want a", bus.user_bits_o); end
    n_checks++; if (bus.locked_o !== 1'b1) begin n_fail++; $display("FAIL good_locked: got %b want 1", bus.locked_o); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL good_sample_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL good_sample[%0d]: got ch%0d %h want ch%0d %h", i, obs_q[i][26:24], obs_q[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_hunt_15();
    do_reset();
    send_sync(9); // too short in hunt: must be ignored
    send_sync(15);
    n_checks++; if (snap_fs !== 1'b1) begin n_fail++; $display("FAIL hunt15_fs: got %b want 1", snap_fs); end
    good_body();
    n_checks++; if (fs_cnt !== 1) begin n_fail++; $display("FAIL hunt15_fs_count: got %0d want 1", fs_cnt); end
    n_checks++; if (bus.user_bits_o !== user_val) begin n_fail++; $display("FAIL hunt15_user: got %h want %h", bus.user_bits_o, user_val); end
    n_checks++; if (bus.locked_o !== 1'b0) begin n_fail++; $display("FAIL hunt15_unlocked: got %b want 0", bus.locked_o); end
    send_sync(10);
    n_checks++; if (snap_lock !== 1'b1) begin n_fail++; $display("FAIL hunt15_lock: got %b want 1", snap_lock); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL hunt15_sample_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hunt15_sample[%0d]: got ch%0d %h want ch%0d %h", i, obs_q[i][26:24], obs_q[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_sep_error();
    do_reset();
    send_sync(10); good_body(); send_sync(10);
    n_checks++; if (snap_lock !== 1'b1) begin n_fail++; $display("FAIL seperr_lock_before: got %b want 1", snap_lock); end
    new_vals(); build_body(5, 2, 1); send_range(0, frm_q.size()); expect_chans(5);
    n_checks++; if (inj_se !== 1'b1) begin n_fail++; $display("FAIL seperr_se: got %b want 1", inj_se); end
    n_checks++; if (inj_lock !== 1'b0) begin n_fail++; $display("FAIL seperr_lock_drop: got %b want 0", inj_lock); end
    send_sync(10);
    n_checks++; if (snap_fs !== 1'b1 || snap_lock !== 1'b0) begin n_fail++; $display("FAIL seperr_resync: got fs=%b lock=%b want fs=1 lock=0", snap_fs, snap_lock); end
    good_body(); send_sync(10);
    n_checks++; if (snap_lock !== 1'b1) begin n_fail++; $display("FAIL seperr_relock: got %b want 1", snap_lock); end
    n_checks++; if (se_cnt !== 1) begin n_fail++; $display("FAIL seperr_se_count: got %0d want 1", se_cnt); end
    n_checks++; if (fs_cnt !== 4) begin n_fail++; $display("FAIL seperr_fs_count: got %0d want 4", fs_cnt); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL seperr_sample_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL seperr_sample[%0d]: got ch%0d %h want ch%0d %h", i, obs_q[i][26:24], obs_q[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_sync_len();
    do_reset();
    send_sync(10); good_body(); send_sync(10); good_body();
    send_sync(9);
    n_checks++; if (sync_pre_lock !== 1'b1) begin n_fail++; $display("FAIL sync9_lock_before: got %b want 1", sync_pre_lock); end
    n_checks++; if (snap_se !== 1'b1 || snap_lock !== 1'b0 || snap_fs !== 1'b0) begin n_fail++; $display("FAIL sync9_err: got se=%b lock=%b fs=%b want se=1 lock=0 fs=0", snap_se, snap_lock, snap_fs); end
    new_vals(); build_body(-1, 0, 0); send_range(0, frm_q.size());
    send_sync(10); good_body(); send_sync(10); good_body();
    send_sync(11);
    n_checks++; if (sync_pre_se !== 1'b1 || sync_pre_lock !== 1'b0) begin n_fail++; $display("FAIL sync11_err: got se=%b lock=%b want se=1 lock=0", sync_pre_se, sync_pre_lock); end
    n_checks++; if (snap_fs !== 1'b1 || snap_se !== 1'b0) begin n_fail++; $display("FAIL sync11_resync: got fs=%b se=%b want fs=1 se=0", snap_fs, snap_se); end
    good_body();
    n_checks++; if (se_cnt !== 2) begin n_fail++; $display("FAIL synclen_se_count: got %0d want 2", se_cnt); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL synclen_sample_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL synclen_sample[%0d]: got ch%0d %h want ch%0d %h", i, obs_q[i][26:24], obs_q[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_invalid();
    do_reset();
    send_sync(10); good_body(); send_sync(10);
    n_checks++; if (snap_lock !== 1'b1) begin n_fail++; $display("FAIL invalid_lock_before: got %b want 1", snap_lock); end
    new_vals(); build_body(2, $urandom_range(0, 5), 2); send_range(0, frm_q.size()); expect_chans(2);
    n_checks++; if (inj_se !== 1'b0 || inj_lock !== 1'b0) begin n_fail++; $display("FAIL invalid_drop: got se=%b lock=%b want se=0 lock=0", inj_se, inj_lock); end
    send_sync(10);
    n_checks++; if (snap_fs !== 1'b1) begin n_fail++; $display("FAIL invalid_resync: got %b want 1", snap_fs); end
    good_body();
    n_checks++; if (se_cnt !== 0) begin n_fail++; $display("FAIL invalid_se_count: got %0d want 0", se_cnt); end
    n_checks++; if (fs_cnt !== 3) begin n_fail++; $display("FAIL invalid_fs_count: got %0d want 3", fs_cnt); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL invalid_sample_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL invalid_sample[%0d]: got ch%0d %h want ch%0d %h", i, obs_q[i][26:24], obs_q[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
    end
  endtask

  task automatic test_mid_reset();
    int cut;
    do_reset();
    send_sync(10); good_body(); send_sync(10);
    new_vals(); build_body(-1, 0, 0);
    cut = $urandom_range(40, 200);
    send_range(0, cut);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.sample_o !== 24'h0 || bus.channel_o !== 3'h0 || bus.user_bits_o !== 4'h0) begin n_fail++; $display("FAIL midrst_data: got sample=%h ch=%h user=%h want 0", bus.sample_o, bus.channel_o, bus.user_bits_o); end
    n_checks++; if (bus.locked_o !== 1'b0) begin n_fail++; $display("FAIL midrst_lock: got %b want 0", bus.locked_o); end
    n_checks++; if (bus.sample_valid_o !== 1'b0 || bus.frame_start_o !== 1'b0 || bus.sync_error_o !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got sv=%b fs=%b se=%b want 0", bus.sample_valid_o, bus.frame_start_o, bus.sync_error_o); end
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete(); fs_cnt = 0; se_cnt = 0;
    send_range(cut, frm_q.size());
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_sample: got %0d samples want 0", obs_q.size()); end
    send_sync(10); good_body();
    n_checks++; if (fs_cnt !== 1) begin n_fail++; $display("FAIL midrst_fs_count: got %0d want 1", fs_cnt); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_sample_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_sample[%0d]: got ch%0d %h want ch%0d %h", i, obs_q[i][26:24], obs_q[i][23:0], exp_q[i][26:24], exp_q[i][23:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_hunt_15();
    test_sep_error();
    test_sync_len();
    test_invalid();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
